// File: rtl/board_painter.sv
// Playfield colour store: erases the old piece, applies row clears and
// paints the new piece once per frame, with a registered colour read port.
module board_painter #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int COLOR_W = 16,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic [3:0][6:0]    blockXPos,
   input  logic [3:0][6:0]    blockYPos,
   input  logic [3:0][6:0]    blockXPrev,
   input  logic [3:0][6:0]    blockYPrev,
   input  logic [COLOR_W-1:0] blockColor,
   input  logic               Clear_row,
   input  logic [3:0]         Num_rows_to_clear,
   input  logic [6:0]         Row_to_clear,
   input  logic [6:0]         rd_x,
   input  logic [6:0]         rd_y,
   output logic [COLOR_W-1:0] rd_color,
   output logic               busy,
   output logic               update_done,
   output logic               frame_overrun
);

   localparam int XW = $clog2(BOARD_W);
   localparam int YW = $clog2(BOARD_H);

   typedef enum logic [1:0] {IDLE, ERASE, CLEAR, PAINT} state_t;

   state_t state, state_n;
   logic [YW-1:0] cnt, cnt_n;

   logic [BOARD_H-1:0][BOARD_W-1:0][COLOR_W-1:0] board;

   logic fr_q, fr_edge, start;

   logic [3:0][6:0]    s_px, s_py, s_qx, s_qy;
   logic [COLOR_W-1:0] s_color;
   logic               s_clear;
   logic [3:0]         s_n;
   logic [6:0]         s_row;
   logic               clr_en;

   logic                           cell_we;
   logic [6:0]                     cx, cy;
   logic [COLOR_W-1:0]             cell_color;
   logic                           row_we;
   logic [YW-1:0]                  row_idx;
   logic [BOARD_W-1:0][COLOR_W-1:0] row_data;
   logic                           rd_ok;
   logic                           done_raw;

   assign fr_edge = frame_clk & ~fr_q;
   assign clr_en  = s_clear && (s_n != 4'd0) && (s_row < 7'(BOARD_H));
   assign rd_ok   = (rd_x < 7'(BOARD_W)) && (rd_y < 7'(BOARD_H));

   // Status outputs are forced low while reset is held.
   assign busy          = (state != IDLE) && !Reset;
   assign update_done   = done_raw && !Reset;
   assign frame_overrun = fr_edge && (state != IDLE) && !Reset;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge Clk) begin
      if (start) begin
         s_px    <= blockXPos;
         s_py    <= blockYPos;
         s_qx    <= blockXPrev;
         s_qy    <= blockYPrev;
         s_color <= blockColor;
         s_clear <= Clear_row;
         s_n     <= Num_rows_to_clear;
         s_row   <= Row_to_clear;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      start      = 1'b0;
      done_raw   = 1'b0;
      cell_we    = 1'b0;
      cx         = '0;
      cy         = '0;
      cell_color = BG_COLOR;
      row_we     = 1'b0;
      row_idx    = '0;
      row_data   = {BOARD_W{BG_COLOR}};
      unique case (state)
         IDLE: begin
            if (fr_edge) begin
               start   = 1'b1;
               state_n = ERASE;
               cnt_n   = '0;
            end
         end
         ERASE: begin
            cx      = s_qx[cnt[1:0]];
            cy      = s_qy[cnt[1:0]];
            cell_we = 1'b1;
            if (cnt == YW'(3)) begin
               if (clr_en) begin
                  state_n = CLEAR;
                  cnt_n   = YW'(s_row);
               end else begin
                  state_n = PAINT;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CLEAR: begin
            // Bottom-up copy: the source row is always above, so not yet overwritten.
            row_we  = 1'b1;
            row_idx = cnt;
            if (7'(cnt) >= 7'(s_n))
               row_data = board[YW'(7'(cnt) - 7'(s_n))];
            if (cnt == '0) begin
               state_n = PAINT;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         PAINT: begin
            cx         = s_px[cnt[1:0]];
            cy         = s_py[cnt[1:0]];
            cell_color = s_color;
            cell_we    = 1'b1;
            if (cnt == YW'(3)) begin
               done_raw = 1'b1;
               state_n  = IDLE;
               cnt_n    = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if ((cx >= 7'(BOARD_W)) || (cy >= 7'(BOARD_H)))
         cell_we = 1'b0;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         board    <= {(BOARD_H*BOARD_W){BG_COLOR}};
         rd_color <= BG_COLOR;
         fr_q     <= 1'b0;
      end else begin
         fr_q <= frame_clk;
         if (row_we)
            board[row_idx] <= row_data;
         if (cell_we)
            board[YW'(cy)][XW'(cx)] <= cell_color;
         rd_color <= rd_ok ? board[YW'(rd_y)][XW'(rd_x)] : BG_COLOR;
      end
   end

endmodule

// File: doc/board_painter.md
Name: board_painter

Overview:
- Downstream consumer of the game-logic stage; owns the per-cell colour store for the playfield.
- On each frame tick it erases the falling piece's previous cells and applies any requested row clear (rows shift down). It then paints the current cells in the piece colour.
- The VGA colour mapper reads cell colours through a registered read port.
- Sequencing erase, clear and paint in one FSM keeps the displayed board consistent with the piece positions and row-clear requests.

Parameters:
- BOARD_W, 10, cells per row (x = 0..BOARD_W-1).
- BOARD_H, 20, rows (y = 0..BOARD_H-1, y=0 top).
- COLOR_W, 16, colour word width.
- BG_COLOR, 16'h0000, empty-cell colour.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  frame tick, level signal; its rising edge starts an update.
- blockXPos  in  7x4  current piece cell X.
- blockYPos  in  7x4  current piece cell Y.
- blockXPrev  in  7x4  previous piece cell X.
- blockYPrev  in  7x4  previous piece cell Y.
- blockColor  in  COLOR_W  current piece colour.
- Clear_row  in  1  row-clear request, sampled at the frame edge.
- Num_rows_to_clear  in  4  number of rows removed.
- Row_to_clear  in  7  lowest row removed.
- rd_x  in  7  read cell X.
- rd_y  in  7  read cell Y.
- rd_color  out  COLOR_W  colour of (rd_x, rd_y), registered.
- busy  out  1  update in progress.
- update_done  out  1  one-cycle pulse when an update completes.
- frame_overrun  out  1  one-cycle pulse when a frame edge arrives while busy.

Behaviour:
- Reset (and its effects) takes priority over all other activity.
  - All cells become BG_COLOR in one cycle.
  - FSM goes to IDLE.
  - busy=0, update_done=0, frame_overrun=0, rd_color=BG_COLOR.
  - frame_clk edge register is cleared.
  - Reset mid-update abandons the update; no partial writes after reset.
- Storage: BOARD_H row registers, each BOARD_W*COLOR_W bits. One row or one cell is written per cycle.
- Edge detect: fr_q <= frame_clk; edge = frame_clk & ~fr_q.
- On edge in IDLE (cycle t), snapshot all block inputs, blockColor, Clear_row, Num_rows_to_clear and Row_to_clear. The FSM uses only snapshots thereafter.
- FSM: IDLE -> ERASE -> CLEAR -> PAINT -> IDLE.
  - ERASE: cycles t+1..t+4. Cell i (i=0..3) is written BG_COLOR at (Prev X[i], Prev Y[i]).
  - CLEAR, entered only if Clear_row=1, Num_rows_to_clear!=0 and Row_to_clear<BOARD_H; otherwise skipped with zero cycles.
    - N=Num_rows_to_clear. One row per cycle, r from Row_to_clear down to 0.
    - row[r] <= row[r-N] if r>=N, else all BG_COLOR.
    - Takes Row_to_clear+1 cycles.
    - N > Row_to_clear+1 clamps naturally: all rows 0..Row_to_clear become BG.
  - PAINT: 4 cycles. Cell i is written blockColor at (XPos[i], YPos[i]).
  - After the last PAINT cycle: update_done=1 for one cycle, FSM returns to IDLE.
- Update latency without clear: 8 cycles from edge to update_done; busy is high for exactly the cycles t+1..t+8.
- Out-of-range coordinates (x>=BOARD_W or y>=BOARD_H) cause the write to be skipped. That cycle is still consumed, so timing is fixed.
- Ordering guarantees:
  - Erase precedes paint, so a cell that is both prev and current ends with blockColor.
  - Duplicate coordinates within a group are harmless.
  - Clear operates on the board after the erase, so the falling piece's old image never shifts with the cleared rows.
- Edge while busy: the update is not started and no snapshot is taken. frame_overrun pulses for 1 cycle in the edge cycle.
- Read port:
  - rd_color <= cell(rd_x, rd_y) each cycle; 1-cycle latency.
  - Out-of-range reads return BG_COLOR.
  - Reads are never stalled. A read in the same cycle as a write to that cell returns the pre-write value.
- All index arithmetic is unsigned 7-bit. r-N is computed only when r>=N, so it never wraps.

Test Plan:
- Reset, then read all 200 cells -> every rd_color = 16'h0000; busy=0.
- Prev all (0,0); Pos=(4,0),(4,1),(5,1),(5,2); colour 16'h0f00; one frame edge -> update_done 8 cycles after edge; those 4 cells read 16'h0f00, all other cells read 0.
- Next frame with Prev = the above and Pos shifted +1 in y; colour unchanged -> (4,0) reads 0; (4,1),(4,2),(5,2),(5,3) read 16'h0f00.
- Fill row 19 with 16'h05f0 and (3,18) with 16'h00a8; then a frame with Clear_row=1, N=1, Row_to_clear=19 and the block out of range (x=127) -> busy lasts 4+20+4 cycles; (3,19)=16'h00a8, row 19 otherwise 0, row 0 all 0.
- Pulse frame_clk again 3 cycles after an edge -> frame_overrun pulses once; no second update_done; board equals single-update result.
- Assert Reset during CLEAR -> next cycle busy=0 and all cells 0; no update_done pulse.
